jstk_poller: RTL and testbench

//  Drives the PMOD joystick SPI master. Issues periodic 40-bit transfers,

---
 rtl/jstk_poller_pkg.sv | 28 ++
 rtl/jstk_poller_if.sv | 24 ++
 rtl/jstk_poller_sync2.sv | 25 ++
 rtl/jstk_poller.sv | 164 ++++++++++++++++
 tb/tb_jstk_poller.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jstk_poller_pkg.sv
// Shared constants for the PMOD joystick poller: command byte,
// reply byte-field offsets and FSM state encodings.
package jstk_poller_pkg;

    localparam logic [5:0] JSTK_CMD_LED = 6'b100000;

    localparam int X_LO_OFF = 32;
    localparam int X_HI_OFF = 24;
    localparam int Y_LO_OFF = 16;
    localparam int Y_HI_OFF = 8;
    localparam int BTN_OFF  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_CAPTURE
    } state_e;

    function automatic logic [9:0] field10(
        input logic [39:0] f,
        input int          lo,
        input int          hi
    );
        return {f[hi +: 2], f[lo +: 8]};
    endfunction

endpackage

// File: rtl/jstk_poller_if.sv
// SPI-master side bundle: transfer request, command frame,
// reply frame and chip select.
interface jstk_poller_if;

    logic        spi_trigger;
    logic [39:0] spi_out_bytes;
    logic [39:0] spi_in_bytes;
    logic        spi_cs;

    modport master (
        output spi_trigger,
        output spi_out_bytes,
        input  spi_in_bytes,
        input  spi_cs
    );

    modport slave (
        input  spi_trigger,
        input  spi_out_bytes,
        output spi_in_bytes,
        output spi_cs
    );

endinterface

// File: rtl/jstk_poller_sync2.sv
// Two-flop synchroniser; resets to 1 so an idle-high CS
// never looks like an active transfer after reset.
module jstk_poller_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/jstk_poller.sv
// PMOD joystick poller: periodic 40-bit SPI polls, reply decode
// and Pong paddle integration of Y deflection.
module jstk_poller
    import jstk_poller_pkg::*;
#(
    parameter int POLL_CYCLES    = 1_000_000,
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int CENTER         = 512,
    parameter int DEADZONE       = 64,
    parameter int STEP           = 4,
    parameter int PADDLE_MAX     = 400,
    parameter int POS_W          = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       led,
    jstk_poller_if.master    spi,
    output logic [9:0]       joy_x,
    output logic [9:0]       joy_y,
    output logic [2:0]       joy_btn,
    output logic             frame_valid,
    output logic [POS_W-1:0] paddle_pos,
    output logic             err
);

    localparam int PW = $clog2(POLL_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PW-1:0]    POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]       Y_HI      = 10'(CENTER + DEADZONE);
    localparam logic [9:0]       Y_LO      = 10'(CENTER - DEADZONE);
    localparam logic [9:0]       JOY_RST   = 10'(CENTER);
    localparam logic [POS_W:0]   MAX_X     = (POS_W+1)'(PADDLE_MAX);
    localparam logic [POS_W:0]   STEP_X    = (POS_W+1)'(STEP);
    localparam logic [POS_W-1:0] STEP_P    = POS_W'(STEP);
    localparam logic [POS_W-1:0] POS_RST   = POS_W'(PADDLE_MAX / 2);

    state_e           state_q;
    logic [PW-1:0]    poll_q;
    logic [TW-1:0]    tmo_q;
    logic             trig_q;
    logic [1:0]       led_q;
    logic [9:0]       x_q;
    logic [9:0]       y_q;
    logic [2:0]       btn_q;
    logic             fv_q;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;
    logic             err_q;
    logic             cs_s;

    logic [9:0]       x_new;
    logic [9:0]       y_new;
    logic [POS_W:0]   up_w;
    logic             unused_bits;

    jstk_poller_sync2 u_cs_sync (
        .clk (clk),
        .rst (rst),
        .d_i (spi.spi_cs),
        .q_o (cs_s)
    );

    assign x_new = field10(spi.spi_in_bytes, X_LO_OFF, X_HI_OFF);
    assign y_new = field10(spi.spi_in_bytes, Y_LO_OFF, Y_HI_OFF);
    assign up_w  = {1'b0, pos_q} + STEP_X;

    assign unused_bits = ^{spi.spi_in_bytes[31:26],
                           spi.spi_in_bytes[15:10],
                           spi.spi_in_bytes[7:3]};

    // Boundary values CENTER+-DEADZONE fall through to "no motion"
    always_comb begin
        pos_d = pos_q;
        if (y_new > Y_HI) begin
            pos_d = (up_w > MAX_X) ? MAX_X[POS_W-1:0] : up_w[POS_W-1:0];
        end else if (y_new < Y_LO) begin
            pos_d = (pos_q < STEP_P) ? '0 : pos_q - STEP_P;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            poll_q  <= '0;
            tmo_q   <= '0;
            trig_q  <= 1'b0;
            led_q   <= 2'b00;
            x_q     <= JOY_RST;
            y_q     <= JOY_RST;
            btn_q   <= 3'b000;
            fv_q    <= 1'b0;
            pos_q   <= POS_RST;
            err_q   <= 1'b0;
        end else begin
            fv_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!enable) begin
                        poll_q <= '0;
                    end else if (poll_q != POLL_LAST) begin
                        poll_q <= poll_q + 1'b1;
                    end else if (cs_s) begin
                        state_q <= ST_REQ;
                        poll_q  <= '0;
                        tmo_q   <= '0;
                        led_q   <= led;
                        trig_q  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (tmo_q == TMO_LAST) begin
                        state_q <= ST_IDLE;
                        trig_q  <= 1'b0;
                        err_q   <= 1'b1;
                        tmo_q   <= '0;
                        poll_q  <= '0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                        if (!cs_s) begin
                            state_q <= ST_XFER;
                            trig_q  <= 1'b0;
                        end
                    end
                end
                ST_XFER: begin
                    if (tmo_q == TMO_LAST) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                        tmo_q   <= '0;
                        poll_q  <= '0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                        if (cs_s) begin
                            state_q <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    x_q     <= x_new;
                    y_q     <= y_new;
                    btn_q   <= spi.spi_in_bytes[BTN_OFF +: 3];
                    pos_q   <= pos_d;
                    fv_q    <= 1'b1;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign spi.spi_trigger   = trig_q;
    assign spi.spi_out_bytes = {JSTK_CMD_LED, led_q, 32'h0};
    assign joy_x             = x_q;
    assign joy_y             = y_q;
    assign joy_btn           = btn_q;
    assign frame_valid       = fv_q;
    assign paddle_pos        = pos_q;
    assign err               = err_q;

endmodule

// File: tb/tb_jstk_poller.sv
// Directed bench for jstk_poller with a behavioural SPI slave
// running a clk/64 SCK (40 bits per transfer).
module tb_jstk_poller;

    localparam int POLL = 64;
    localparam int TMO  = 4096;
    localparam int PMAX = 18;
    localparam int SCK  = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] led;
    logic [9:0] joy_x;
    logic [9:0] joy_y;
    logic [2:0] joy_btn;
    logic       frame_valid;
    logic [9:0] paddle_pos;
    logic       err;

    logic [39:0] reply;
    bit          hang;
    int          n_vec;
    int          n_bad;

    jstk_poller_if bus ();

    jstk_poller #(
        .POLL_CYCLES    (POLL),
        .TIMEOUT_CYCLES (TMO),
        .PADDLE_MAX     (PMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .led         (led),
        .spi         (bus.master),
        .joy_x       (joy_x),
        .joy_y       (joy_y),
        .joy_btn     (joy_btn),
        .frame_valid (frame_valid),
        .paddle_pos  (paddle_pos),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Slave: drop CS a few clocks after a request, clock 40 bits,
    // present the reply one SCK before CS rises.
    initial begin
        bus.spi_cs       = 1'b1;
        bus.spi_in_bytes = '0;
        forever begin
            @(negedge clk);
            if (bus.spi_trigger && bus.spi_cs) begin
                repeat (4) @(negedge clk);
                bus.spi_cs = 1'b0;
                while (hang) @(negedge clk);
                repeat (39 * SCK) @(negedge clk);
                bus.spi_in_bytes = reply;
                repeat (SCK) @(negedge clk);
                bus.spi_cs = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [39:0] got,
                       input logic [39:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] mk(input logic [9:0] x,
                                       input logic [9:0] y,
                                       input logic [2:0] b);
        return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (frame_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_trig(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (bus.spi_trigger) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cs_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (!bus.spi_cs) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic frame(input string tag, input logic [39:0] r,
                         input int exp_pos);
        bit ok;
        reply = r;
        wait_fv(ok);
        chk({tag, " valid"}, 40'(ok), 40'd1);
        chk({tag, " pos"}, 40'(paddle_pos), 40'(exp_pos));
    endtask

    task automatic idle_no_trig(input string tag, input int n);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.spi_trigger) seen = 1'b1;
        end
        chk(tag, 40'(seen), 40'd0);
    endtask

    initial begin
        bit ok;
        bit seen;
        int n;

        n_vec  = 0;
        n_bad  = 0;
        hang   = 1'b0;
        rst    = 1'b1;
        enable = 1'b0;
        led    = 2'b00;
        reply  = '0;
        repeat (3) tick();

        chk("rst trig", 40'(bus.spi_trigger), 40'd0);
        chk("rst out", bus.spi_out_bytes, 40'h80_0000_0000);
        chk("rst x", 40'(joy_x), 40'd512);
        chk("rst y", 40'(joy_y), 40'd512);
        chk("rst btn", 40'(joy_btn), 40'd0);
        chk("rst fv", 40'(frame_valid), 40'd0);
        chk("rst pos", 40'(paddle_pos), 40'd9);
        chk("rst err", 40'(err), 40'd0);
        rst = 1'b0;

        idle_no_trig("enable low holds", 3 * POLL);
        enable = 1'b1;

        // Decode and single-pulse check
        frame("t1", 40'h34_02_78_01_05, 5);
        chk("t1 x", 40'(joy_x), 40'd564);
        chk("t1 y", 40'(joy_y), 40'd376);
        chk("t1 btn", 40'(joy_btn), 40'h5);
        chk("t1 err", 40'(err), 40'd0);
        tick();
        chk("t1 pulse", 40'(frame_valid), 40'd0);

        // Deadzone boundaries, motion and both clamps (PADDLE_MAX=18)
        frame("dz hi", mk(10'd576, 10'd576, 3'd0), 5);
        frame("dz lo", mk(10'd448, 10'd448, 3'd0), 5);
        frame("up 577", mk(10'd1023, 10'd577, 3'd3), 9);
        chk("x 1023", 40'(joy_x), 40'd1023);
        chk("btn 3", 40'(joy_btn), 40'd3);
        frame("up 700a", mk(10'd0, 10'd700, 3'd0), 13);
        frame("up 700b", mk(10'd0, 10'd700, 3'd0), 17);
        frame("clamp hi", mk(10'd0, 10'd1000, 3'd0), 18);
        frame("dn 447", mk(10'd0, 10'd447, 3'd0), 14);
        frame("dn 0a", mk(10'd0, 10'd0, 3'd0), 10);
        frame("dn 0b", mk(10'd0, 10'd0, 3'd0), 6);
        frame("dn 0c", mk(10'd0, 10'd0, 3'd0), 2);
        frame("clamp lo", mk(10'd0, 10'd0, 3'd0), 0);
        frame("stay lo", mk(10'd0, 10'd0, 3'd0), 0);

        // LED latch at REQ entry, enable dropped mid-transfer
        led   = 2'b10;
        reply = mk(10'd100, 10'd512, 3'd1);
        wait_trig(ok);
        chk("led trig", 40'(ok), 40'd1);
        chk("led out", bus.spi_out_bytes, 40'h82_0000_0000);
        wait_cs_low(ok);
        chk("led cs", 40'(ok), 40'd1);
        led    = 2'b01;
        enable = 1'b0;
        wait_fv(ok);
        chk("en-off completes", 40'(ok), 40'd1);
        chk("led held", bus.spi_out_bytes, 40'h82_0000_0000);
        chk("en-off x", 40'(joy_x), 40'd100);
        idle_no_trig("en-off holds", 3 * POLL);
        enable = 1'b1;

        // Timeout: slave holds CS low
        hang  = 1'b1;
        reply = mk(10'd0, 10'd700, 3'd0);
        wait_trig(ok);
        chk("tmo trig", 40'(ok), 40'd1);
        n    = 0;
        seen = 1'b0;
        while (!err && n < TMO + 500) begin
            tick();
            n++;
            if (frame_valid) seen = 1'b1;
        end
        chk("tmo cycles", 40'(n), 40'(TMO));
        chk("tmo err", 40'(err), 40'd1);
        chk("tmo trig low", 40'(bus.spi_trigger), 40'd0);
        chk("tmo no fv", 40'(seen), 40'd0);
        chk("tmo x kept", 40'(joy_x), 40'd100);
        hang = 1'b0;
        frame("retry", mk(10'd0, 10'd700, 3'd0), 4);
        chk("retry err clr", 40'(err), 40'd0);

        // Reset while CS is low
        reply = mk(10'd0, 10'd1000, 3'd7);
        wait_trig(ok);
        wait_cs_low(ok);
        chk("rst2 cs", 40'(ok), 40'd1);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        chk("rst2 trig", 40'(bus.spi_trigger), 40'd0);
        chk("rst2 pos", 40'(paddle_pos), 40'd9);
        chk("rst2 x", 40'(joy_x), 40'd512);
        chk("rst2 out", bus.spi_out_bytes, 40'h80_0000_0000);
        rst  = 1'b0;
        seen = 1'b0;
        n    = 0;
        while (!bus.spi_cs && n < 4000) begin
            tick();
            n++;
            if (bus.spi_trigger) seen = 1'b1;
        end
        chk("rst2 blocked", 40'(seen), 40'd0);
        chk("rst2 pos kept", 40'(paddle_pos), 40'd9);
        frame("rst2 next", mk(10'd0, 10'd700, 3'd0), 13);
        chk("rst2 btn", 40'(joy_btn), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
